// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands, detects load-use
// hazards against the instruction in EX, and counts inserted bubbles and flushes.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic [1:0]           id_jal_i,
    input  logic [1:0]           id_alu_src_a_i,
    input  logic [1:0]           id_alu_src_b_i,
    input  logic                 id_mem_to_reg_i,
    input  logic                 id_reg_write_i,
    input  logic                 id_mem_read_i,
    input  logic                 id_mem_write_i,
    input  logic                 id_branch_i,
    input  logic [3:0]           id_alu_control_i,
    input  logic [XLEN-1:0]      id_pc_i,
    input  logic [XLEN-1:0]      id_rs1_data_i,
    input  logic [XLEN-1:0]      id_rs2_data_i,
    input  logic [XLEN-1:0]      id_imm_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic [4:0]           id_rd_i,
    output logic                 ex_valid_o,
    output logic [1:0]           ex_jal_o,
    output logic [1:0]           ex_alu_src_a_o,
    output logic [1:0]           ex_alu_src_b_o,
    output logic                 ex_mem_to_reg_o,
    output logic                 ex_reg_write_o,
    output logic                 ex_mem_read_o,
    output logic                 ex_mem_write_o,
    output logic                 ex_branch_o,
    output logic [3:0]           ex_alu_control_o,
    output logic [XLEN-1:0]      ex_pc_o,
    output logic [XLEN-1:0]      ex_rs1_data_o,
    output logic [XLEN-1:0]      ex_rs2_data_o,
    output logic [XLEN-1:0]      ex_imm_o,
    output logic [4:0]           ex_rs1_o,
    output logic [4:0]           ex_rs2_o,
    output logic [4:0]           ex_rd_o,
    output logic                 stall_o,
    output logic [CNT_W-1:0]     bubble_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 lu_c;
    logic                 bubble_c;
    logic                 d_valid;
    logic [SEL_W-1:0]     d_jal;
    logic [SEL_W-1:0]     d_alu_src_a;
    logic [SEL_W-1:0]     d_alu_src_b;
    logic                 d_mem_to_reg;
    logic                 d_reg_write;
    logic                 d_mem_read;
    logic                 d_mem_write;
    logic                 d_branch;
    logic [ALU_W-1:0]     d_alu_control;
    logic [XLEN-1:0]      d_pc;
    logic [XLEN-1:0]      d_rs1_data;
    logic [XLEN-1:0]      d_rs2_data;
    logic [XLEN-1:0]      d_imm;
    logic [REG_W-1:0]     d_rs1;
    logic [REG_W-1:0]     d_rs2;
    logic [REG_W-1:0]     d_rd;
    logic [CNT_W-1:0]     d_bubble_cnt;
    logic [CNT_W-1:0]     d_flush_cnt;

    // Load in EX whose destination is read by the ID instruction (rs2 compared unconditionally)
    always_comb begin
        lu_c = ex_valid_o & ex_mem_read_o & (ex_rd_o != REG_W'(0)) & id_valid_i &
               ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i));
    end

    // A wrong-path ID instruction must not stall the front end
    always_comb begin
        stall_o = hold_i | (lu_c & ~flush_i);
    end

    always_comb begin
        bubble_c = flush_i | lu_c;
    end

    // Next-state: hold keeps everything, bubbles zero only the control bundle
    always_comb begin
        d_valid       = ex_valid_o;
        d_jal         = ex_jal_o;
        d_alu_src_a   = ex_alu_src_a_o;
        d_alu_src_b   = ex_alu_src_b_o;
        d_mem_to_reg  = ex_mem_to_reg_o;
        d_reg_write   = ex_reg_write_o;
        d_mem_read    = ex_mem_read_o;
        d_mem_write   = ex_mem_write_o;
        d_branch      = ex_branch_o;
        d_alu_control = ex_alu_control_o;
        d_pc          = ex_pc_o;
        d_rs1_data    = ex_rs1_data_o;
        d_rs2_data    = ex_rs2_data_o;
        d_imm         = ex_imm_o;
        d_rs1         = ex_rs1_o;
        d_rs2         = ex_rs2_o;
        d_rd          = ex_rd_o;
        d_bubble_cnt  = bubble_cnt_o;
        d_flush_cnt   = flush_cnt_o;

        if (!hold_i) begin
            d_pc       = id_pc_i;
            d_rs1_data = id_rs1_data_i;
            d_rs2_data = id_rs2_data_i;
            d_imm      = id_imm_i;
            d_rs1      = id_rs1_i;
            d_rs2      = id_rs2_i;
            d_rd       = id_rd_i;

            if (bubble_c) begin
                d_valid       = 1'b0;
                d_jal         = SEL_W'(0);
                d_alu_src_a   = SEL_W'(0);
                d_alu_src_b   = SEL_W'(0);
                d_mem_to_reg  = 1'b0;
                d_reg_write   = 1'b0;
                d_mem_read    = 1'b0;
                d_mem_write   = 1'b0;
                d_branch      = 1'b0;
                d_alu_control = ALU_W'(0);
            end else begin
                d_valid       = id_valid_i;
                d_jal         = id_jal_i;
                d_alu_src_a   = id_alu_src_a_i;
                d_alu_src_b   = id_alu_src_b_i;
                d_mem_to_reg  = id_mem_to_reg_i;
                d_reg_write   = id_reg_write_i;
                d_mem_read    = id_mem_read_i;
                d_mem_write   = id_mem_write_i;
                d_branch      = id_branch_i;
                d_alu_control = id_alu_control_i;
            end

            // Flush takes credit when both causes coincide
            if (flush_i) begin
                if (flush_cnt_o != CNT_MAX) begin
                    d_flush_cnt = flush_cnt_o + CNT_W'(1);
                end
            end else if (lu_c) begin
                if (bubble_cnt_o != CNT_MAX) begin
                    d_bubble_cnt = bubble_cnt_o + CNT_W'(1);
                end
            end
        end
    end

    // Stage register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_o       <= 1'b0;
            ex_jal_o         <= SEL_W'(0);
            ex_alu_src_a_o   <= SEL_W'(0);
            ex_alu_src_b_o   <= SEL_W'(0);
            ex_mem_to_reg_o  <= 1'b0;
            ex_reg_write_o   <= 1'b0;
            ex_mem_read_o    <= 1'b0;
            ex_mem_write_o   <= 1'b0;
            ex_branch_o      <= 1'b0;
            ex_alu_control_o <= ALU_W'(0);
            ex_pc_o          <= XLEN'(0);
            ex_rs1_data_o    <= XLEN'(0);
            ex_rs2_data_o    <= XLEN'(0);
            ex_imm_o         <= XLEN'(0);
            ex_rs1_o         <= REG_W'(0);
            ex_rs2_o         <= REG_W'(0);
            ex_rd_o          <= REG_W'(0);
            bubble_cnt_o     <= CNT_W'(0);
            flush_cnt_o      <= CNT_W'(0);
        end else begin
            ex_valid_o       <= d_valid;
            ex_jal_o         <= d_jal;
            ex_alu_src_a_o   <= d_alu_src_a;
            ex_alu_src_b_o   <= d_alu_src_b;
            ex_mem_to_reg_o  <= d_mem_to_reg;
            ex_reg_write_o   <= d_reg_write;
            ex_mem_read_o    <= d_mem_read;
            ex_mem_write_o   <= d_mem_write;
            ex_branch_o      <= d_branch;
            ex_alu_control_o <= d_alu_control;
            ex_pc_o          <= d_pc;
            ex_rs1_data_o    <= d_rs1_data;
            ex_rs2_data_o    <= d_rs2_data;
            ex_imm_o         <= d_imm;
            ex_rs1_o         <= d_rs1;
            ex_rs2_o         <= d_rs2;
            ex_rd_o          <= d_rd;
            bubble_cnt_o     <= d_bubble_cnt;
            flush_cnt_o      <= d_flush_cnt;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations, a negedge
// monitor pops and compares EX contents, counters and stall.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    // ctrl packing: {jal[1:0], src_a[1:0], src_b[1:0], m2r, rw, mr, mw, br, alu[3:0]}
    localparam logic [14:0] C_LW   = 15'b00_00_01_1_1_1_0_0_0000;
    localparam logic [14:0] C_ADD  = 15'b00_00_00_0_1_0_0_0_0010;
    localparam logic [14:0] C_NONE = 15'b0;

    typedef struct packed {
        logic        valid;
        logic [14:0] ctrl;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ex_t;

    typedef struct packed {
        ex_t        ex;
        logic [3:0] bcnt;
        logic [3:0] fcnt;
        logic       stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic hold_i, flush_i, id_valid_i;
    logic [1:0] id_jal_i, id_alu_src_a_i, id_alu_src_b_i;
    logic id_mem_to_reg_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_branch_i;
    logic [3:0] id_alu_control_i;
    logic [XLEN-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic ex_valid_o;
    logic [1:0] ex_jal_o, ex_alu_src_a_o, ex_alu_src_b_o;
    logic ex_mem_to_reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o;
    logic [3:0] ex_alu_control_o;
    logic [XLEN-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic stall_o;
    logic [CNT_W-1:0] bubble_cnt_o, flush_cnt_o;

    int tests  = 0;
    int errors = 0;
    exp_t sb_q[$];
    exp_t e;
    ex_t  act;
    logic [31:0] exp_d1, exp_d2, exp_im;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_jal_i(id_jal_i),
        .id_alu_src_a_i(id_alu_src_a_i), .id_alu_src_b_i(id_alu_src_b_i),
        .id_mem_to_reg_i(id_mem_to_reg_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .id_branch_i(id_branch_i), .id_alu_control_i(id_alu_control_i),
        .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .ex_valid_o(ex_valid_o), .ex_jal_o(ex_jal_o),
        .ex_alu_src_a_o(ex_alu_src_a_o), .ex_alu_src_b_o(ex_alu_src_b_o),
        .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_branch_o(ex_branch_o), .ex_alu_control_o(ex_alu_control_o),
        .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    function automatic ex_t mk(input logic v, input logic [14:0] c, input logic [31:0] pc,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        ex_t x;
        x.valid = v; x.ctrl = c; x.pc = pc; x.rs1 = r1; x.rs2 = r2; x.rd = rd;
        return x;
    endfunction

    // Drive one cycle of ID inputs and queue what must be visible before the next edge
    task automatic step(input logic rst, input logic h, input logic f,
                        input logic [14:0] c, input logic [31:0] pc,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input ex_t eex, input logic [3:0] eb, input logic [3:0] ef,
                        input logic es);
        exp_t x;
        @(posedge clk);
        #1;
        reset            = rst;
        hold_i           = h;
        flush_i          = f;
        id_valid_i       = 1'b1;
        {id_jal_i, id_alu_src_a_i, id_alu_src_b_i, id_mem_to_reg_i, id_reg_write_i,
         id_mem_read_i, id_mem_write_i, id_branch_i, id_alu_control_i} = c;
        id_pc_i          = pc;
        id_rs1_data_i    = pc + 32'd1;
        id_rs2_data_i    = pc + 32'd2;
        id_imm_i         = pc + 32'd3;
        id_rs1_i         = r1;
        id_rs2_i         = r2;
        id_rd_i          = rd;
        x.ex = eex; x.bcnt = eb; x.fcnt = ef; x.stall = es;
        sb_q.push_back(x);
    endtask

    // Monitor: compare the EX register image, counters and stall at mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act.valid = ex_valid_o;
            act.ctrl  = {ex_jal_o, ex_alu_src_a_o, ex_alu_src_b_o, ex_mem_to_reg_o,
                         ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o,
                         ex_alu_control_o};
            act.pc  = ex_pc_o;
            act.rs1 = ex_rs1_o;
            act.rs2 = ex_rs2_o;
            act.rd  = ex_rd_o;
            exp_d1 = (e.ex.pc == 32'd0) ? 32'd0 : e.ex.pc + 32'd1;
            exp_d2 = (e.ex.pc == 32'd0) ? 32'd0 : e.ex.pc + 32'd2;
            exp_im = (e.ex.pc == 32'd0) ? 32'd0 : e.ex.pc + 32'd3;
            tests++;
            if (act != e.ex || ex_rs1_data_o != exp_d1 || ex_rs2_data_o != exp_d2
                || ex_imm_o != exp_im) begin
                errors++;
                $display("FAIL ex_regs t=%0t got v=%0b ctrl=%h pc=%h rs1=%0d rs2=%0d rd=%0d d1=%h d2=%h imm=%h want v=%0b ctrl=%h pc=%h rs1=%0d rs2=%0d rd=%0d",
                         $time, act.valid, act.ctrl, act.pc, act.rs1, act.rs2, act.rd,
                         ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
                         e.ex.valid, e.ex.ctrl, e.ex.pc, e.ex.rs1, e.ex.rs2, e.ex.rd);
            end
            tests++;
            if (bubble_cnt_o != e.bcnt || flush_cnt_o != e.fcnt) begin
                errors++;
                $display("FAIL counters t=%0t got bubble=%0d flush=%0d want bubble=%0d flush=%0d",
                         $time, bubble_cnt_o, flush_cnt_o, e.bcnt, e.fcnt);
            end
            tests++;
            if (stall_o != e.stall) begin
                errors++;
                $display("FAIL stall t=%0t got %0b want %0b", $time, stall_o, e.stall);
            end
        end
    end

    initial begin
        ex_t z;
        int  fexp;
        z = '0;
        reset = 1'b0; hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
        {id_jal_i, id_alu_src_a_i, id_alu_src_b_i, id_mem_to_reg_i, id_reg_write_i,
         id_mem_read_i, id_mem_write_i, id_branch_i, id_alu_control_i} = '0;
        id_pc_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;

        // reset with live inputs; stall follows hold only
        step(1'b0, 1'b0, 1'b0, C_LW,  32'h100, 5'd3, 5'd4, 5'd9, z, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, C_LW,  32'h100, 5'd3, 5'd4, 5'd9, z, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h104, 5'd1, 5'd2, 5'd5, z, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_LW,  32'h108, 5'd2, 5'd0, 5'd7,
             mk(1'b1, C_ADD, 32'h104, 5'd1, 5'd2, 5'd5), 4'd0, 4'd0, 1'b0);
        // load-use on rs2
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h10c, 5'd1, 5'd7, 5'd8,
             mk(1'b1, C_LW, 32'h108, 5'd2, 5'd0, 5'd7), 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h10c, 5'd1, 5'd7, 5'd8,
             mk(1'b0, C_NONE, 32'h10c, 5'd1, 5'd7, 5'd8), 4'd1, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_LW,  32'h110, 5'd0, 5'd0, 5'd0,
             mk(1'b1, C_ADD, 32'h10c, 5'd1, 5'd7, 5'd8), 4'd1, 4'd0, 1'b0);
        // load to x0 never stalls
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h114, 5'd0, 5'd3, 5'd7,
             mk(1'b1, C_LW, 32'h110, 5'd0, 5'd0, 5'd0), 4'd1, 4'd0, 1'b0);
        // non-load producer never stalls
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h118, 5'd7, 5'd1, 5'd9,
             mk(1'b1, C_ADD, 32'h114, 5'd0, 5'd3, 5'd7), 4'd1, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_LW,  32'h11c, 5'd2, 5'd0, 5'd7,
             mk(1'b1, C_ADD, 32'h118, 5'd7, 5'd1, 5'd9), 4'd1, 4'd0, 1'b0);
        // flush together with load-use
        step(1'b1, 1'b0, 1'b1, C_ADD, 32'h120, 5'd7, 5'd0, 5'd3,
             mk(1'b1, C_LW, 32'h11c, 5'd2, 5'd0, 5'd7), 4'd1, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h124, 5'd1, 5'd2, 5'd4,
             mk(1'b0, C_NONE, 32'h120, 5'd7, 5'd0, 5'd3), 4'd1, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_LW,  32'h128, 5'd1, 5'd2, 5'd10,
             mk(1'b1, C_ADD, 32'h124, 5'd1, 5'd2, 5'd4), 4'd1, 4'd1, 1'b0);
        // hold for three edges with a hazard present
        step(1'b1, 1'b1, 1'b0, C_ADD, 32'h12c, 5'd10, 5'd0, 5'd11,
             mk(1'b1, C_LW, 32'h128, 5'd1, 5'd2, 5'd10), 4'd1, 4'd1, 1'b1);
        step(1'b1, 1'b1, 1'b0, C_ADD, 32'h130, 5'd0, 5'd10, 5'd12,
             mk(1'b1, C_LW, 32'h128, 5'd1, 5'd2, 5'd10), 4'd1, 4'd1, 1'b1);
        step(1'b1, 1'b1, 1'b0, C_ADD, 32'h134, 5'd10, 5'd10, 5'd13,
             mk(1'b1, C_LW, 32'h128, 5'd1, 5'd2, 5'd10), 4'd1, 4'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h134, 5'd10, 5'd10, 5'd13,
             mk(1'b1, C_LW, 32'h128, 5'd1, 5'd2, 5'd10), 4'd1, 4'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h134, 5'd10, 5'd10, 5'd13,
             mk(1'b0, C_NONE, 32'h134, 5'd10, 5'd10, 5'd13), 4'd2, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h138, 5'd1, 5'd1, 5'd1,
             mk(1'b1, C_ADD, 32'h134, 5'd10, 5'd10, 5'd13), 4'd2, 4'd1, 1'b0);
        // 20 consecutive flushes: flush counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            fexp = (i + 1 > 15) ? 15 : i + 1;
            if (i == 0)
                step(1'b1, 1'b0, 1'b1, C_ADD, 32'h200, 5'd0, 5'd0, 5'd5,
                     mk(1'b1, C_ADD, 32'h138, 5'd1, 5'd1, 5'd1), 4'd2, 4'(fexp), 1'b0);
            else
                step(1'b1, 1'b0, 1'b1, C_ADD, 32'h200 + 32'(4 * i), 5'(i), 5'd0, 5'd5,
                     mk(1'b0, C_NONE, 32'h200 + 32'(4 * (i - 1)), 5'(i - 1), 5'd0, 5'd5),
                     4'd2, 4'(fexp), 1'b0);
        end
        // asynchronous reset mid-sequence clears immediately
        step(1'b0, 1'b0, 1'b1, C_ADD, 32'h250, 5'd1, 5'd2, 5'd3, z, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_ADD, 32'h300, 5'd2, 5'd3, 5'd5, z, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, C_LW,  32'h304, 5'd6, 5'd6, 5'd6,
             mk(1'b1, C_ADD, 32'h300, 5'd2, 5'd3, 5'd5), 4'd0, 4'd0, 1'b0);

        repeat (3) @(posedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode (ID) and execute (EX) of the pipelined RISC-V core. It latches the decoded control bundle (ALU selects, memory and write-back controls, branch/jump controls, 4-bit ALU operation) and the ID-stage operands. It also detects load-use hazards against the instruction already in EX. On a hazard, on a redirect flush, or on a downstream hold it inserts bubbles or freezes, and it keeps saturating event counters for bubbles and flushes.

## Interface
- XLEN, 32, datapath/PC width
- CNT_W, 16, width of each event counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- hold_i  in  1  downstream freeze (EX/MEM busy); stage keeps its contents
- flush_i  in  1  redirect (taken branch/JAL resolved); squash the instruction entering EX
- id_valid_i  in  1  ID holds a real instruction
- id_jal_i, id_alu_src_a_i, id_alu_src_b_i  in  2 each  control bundle from the decode control unit
- id_mem_to_reg_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_branch_i  in  1 each  control bundle
- id_alu_control_i  in  4  ALU operation
- id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN each  operands
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices
- ex_* outputs  out  same widths  registered copies of every id_* input (ex_valid_o, ex_jal_o … ex_rd_o)
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- Load-use hazard (combinational): lu = ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & id_valid_i & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)). Index comparison is conservative: it does not consider whether the instruction actually reads rs2.
- Per-edge action, priority order:
  1. hold_i=1: all ex_* registers keep their values; counters unchanged.
  2. flush_i=1: bubble; flush_cnt += 1.
  3. lu=1: bubble; bubble_cnt += 1.
  4. Otherwise: load every ex_* from id_*.
- Bubble: ex_valid, jal, alu_src_a/b, mem_to_reg, reg_write, mem_read, mem_write, branch and alu_control are all 0. Data and index fields (pc, rs*_data, imm, rs1/rs2/rd) still load from id_*, so the bubble is a deterministic NOP.
- stall_o = hold_i | (lu & ~flush_i). A flush cancels a load-use stall, because the ID instruction is wrong-path.
- Counters saturate at 2^CNT_W−1 and never wrap. A cycle with flush_i and lu both set increments only flush_cnt.
- Reset (asserted low, asynchronous): every ex_* output is 0 and both counters are 0. stall_o then reflects hold_i only, because ex_valid=0 forces lu=0. Reset asserted in the middle of a stall or hold clears the stage immediately, with no pending state retained.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall_o is combinational from hold_i, flush_i, the id_rs indices and the registered ex_* fields. It is valid in the same cycle, with no registered delay.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read_o=0, so lu deasserts and the held ID instruction advances on the next edge.
- hold_i dominates indefinitely. A hazard present during hold is re-evaluated when hold_i drops, and no bubble is counted while hold_i=1.
- Reset deassertion is taken synchronously. The first capture occurs on the first rising edge with reset=1.

## Test plan
- Reset: drive arbitrary id_* values with reset=0. Required: all ex_* = 0, bubble_cnt=flush_cnt=0, stall_o=0. Release reset, then load id_alu_control=4'h2, id_rd=5. Next edge: ex_alu_control=2, ex_rd=5, ex_valid=1.
- Load-use: in EX, lw with ex_rd=7 and ex_mem_read=1; in ID, add with rs2=7. Required: stall_o=1 for 1 cycle, next ex_valid=0 with all controls 0, bubble_cnt=1. The following edge loads the add.
- x0 and non-load: ex_rd=0 with mem_read=1 gives no stall. ex_rd=7 with mem_read=0 and rs1=7 gives no stall.
- Flush vs hazard: the load-use condition and flush_i=1 in the same cycle. Required: stall_o=0, bubble inserted, flush_cnt=1, bubble_cnt=0.
- Hold: hold_i=1 for 3 cycles while ID inputs change and a hazard is present. Required: ex_* frozen, stall_o=1, counters unchanged. On release, a single bubble is inserted and bubble_cnt increments by 1.
- Saturation: with CNT_W=4, apply 20 consecutive flushes. Required: flush_cnt stays at 15. Then assert reset mid-sequence: counters read 0 immediately.
